// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: CPU load/store stage versus debug port, with a
// starvation counter for debug and debug-only ownership once the CPU halts.
module dmem_arbiter #(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_rw,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {RUN, HALTED} state_t;

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  state_t     state, state_next;
  logic [3:0] wait_cnt, wait_next;
  logic       cpu_acc, dbg_acc;
  logic       iss_cpu_rd, iss_dbg_rd;
  logic       ret_cpu, ret_dbg;

  // Grant decision; nothing is granted while reset is asserted.
  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    cpu_acc    = 1'b0;
    dbg_acc    = 1'b0;
    cpu_stall  = 1'b0;
    if (rst) begin
      case (state)
        RUN: begin
          if (halt) state_next = HALTED;
          if (wait_cnt == WAIT_MAX && dbg_req) begin
            dbg_acc   = 1'b1;
            cpu_stall = cpu_req;
          end else begin
            cpu_acc = cpu_req;
            dbg_acc = dbg_req & ~cpu_req;
          end
        end
        HALTED: dbg_acc = dbg_req;
        default: state_next = RUN;
      endcase
      if (dbg_req && !dbg_acc)
        wait_next = (wait_cnt == WAIT_MAX) ? wait_cnt : 4'(wait_cnt + 4'd1);
      else
        wait_next = 4'd0;
    end
  end

  // Issue register plus a two-stage read-owner tag aligned with mem_rdata.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= RUN;
      wait_cnt   <= 4'd0;
      mem_en     <= 1'b0;
      mem_rw     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      iss_cpu_rd <= 1'b0;
      iss_dbg_rd <= 1'b0;
      ret_cpu    <= 1'b0;
      ret_dbg    <= 1'b0;
    end else begin
      state      <= state_next;
      wait_cnt   <= wait_next;
      mem_en     <= cpu_acc | dbg_acc;
      if (cpu_acc) begin
        mem_rw    <= cpu_we;
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
      end else if (dbg_acc) begin
        mem_rw    <= dbg_we;
        mem_addr  <= dbg_addr;
        mem_wdata <= dbg_wdata;
      end else begin
        mem_rw    <= 1'b0;
      end
      iss_cpu_rd <= cpu_acc & ~cpu_we;
      iss_dbg_rd <= dbg_acc & ~dbg_we;
      ret_cpu    <= iss_cpu_rd;
      ret_dbg    <= iss_dbg_rd;
    end
  end

  assign dbg_gnt    = dbg_acc;
  assign cpu_rvalid = ret_cpu;
  assign dbg_rvalid = ret_dbg;
  assign cpu_rdata  = ret_cpu ? mem_rdata : '0;
  assign dbg_rdata  = ret_dbg ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a one-cycle-latency memory model.
module tb_dmem_arbiter;

  localparam int AW = 8;
  localparam int DW = 64;

  logic          clk;
  logic          rst;
  logic          halt;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_stall, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          dbg_req, dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_gnt, dbg_rvalid;
  logic [DW-1:0] dbg_rdata;
  logic          mem_rw, mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] mem [0:255];

  int tests = 0;
  int fails = 0;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst), .halt(halt),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_rw(mem_rw), .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: write or read on the strobe, read data next cycle.
  always @(posedge clk) begin
    if (mem_en && mem_rw) mem[mem_addr] <= mem_wdata;
    else if (mem_en)      mem_rdata     <= mem[mem_addr];
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    halt = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0; idle_inputs();
    cpu_req = 1'b1; dbg_req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      tests++;
      if ({mem_en, cpu_rvalid, dbg_rvalid, cpu_stall, dbg_gnt} !== 5'b0) begin
        fails++;
        $display("[TB] FAIL reset_outputs cycle %0d: en/crv/drv/stall/gnt=%b required 00000",
                 c, {mem_en, cpu_rvalid, dbg_rvalid, cpu_stall, dbg_gnt});
      end
    end
    tests++;
    if (mem_addr !== 8'd0 || mem_wdata !== 64'd0) begin
      fails++;
      $display("[TB] FAIL reset_mem_bus: addr=%0h wdata=%0h required 0", mem_addr, mem_wdata);
    end
    next_cycle();
    rst = 1'b1; idle_inputs();
    next_cycle();
  endtask

  task automatic test_cpu_only();
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      idle_inputs();
      if (c == 0) begin cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'd8; cpu_wdata = 64'd55; end
      if (c == 1) begin cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'd8; end
      @(negedge clk);
      tests++;
      if (cpu_stall !== 1'b0) begin
        fails++;
        $display("[TB] FAIL cpu_stall cycle %0d: got %b required 0", c, cpu_stall);
      end
      if (c == 1) begin
        tests++;
        if ({mem_en, mem_rw} !== 2'b11 || mem_addr !== 8'd8 || mem_wdata !== 64'd55) begin
          fails++;
          $display("[TB] FAIL cpu_store_issue: en=%b rw=%b addr=%0d wdata=%0d required 1 1 8 55",
                   mem_en, mem_rw, mem_addr, mem_wdata);
        end
      end
      if (c == 2) begin
        tests++;
        if ({mem_en, mem_rw} !== 2'b10 || cpu_rvalid !== 1'b0) begin
          fails++;
          $display("[TB] FAIL cpu_load_issue: en=%b rw=%b rvalid=%b required 1 0 0",
                   mem_en, mem_rw, cpu_rvalid);
        end
      end
      if (c == 3) begin
        tests++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 64'd55 || dbg_rvalid !== 1'b0 || dbg_rdata !== 64'd0) begin
          fails++;
          $display("[TB] FAIL cpu_load_return: crv=%b crd=%0d drv=%b drd=%0d required 1 55 0 0",
                   cpu_rvalid, cpu_rdata, dbg_rvalid, dbg_rdata);
        end
      end
      if (c == 4) begin
        tests++;
        if (cpu_rvalid !== 1'b0) begin
          fails++;
          $display("[TB] FAIL cpu_rvalid_single: got %b required 0", cpu_rvalid);
        end
      end
    end
  endtask

  task automatic test_contention();
    mem[16] = 64'd7;
    for (int c = 0; c < 7; c++) begin
      next_cycle();
      idle_inputs();
      cpu_req = 1'b1; cpu_addr = 8'd0;
      dbg_req = (c <= 4); dbg_addr = 8'd16;
      @(negedge clk);
      if (c <= 4) begin
        tests++;
        if (dbg_gnt !== (c == 4) || cpu_stall !== (c == 4)) begin
          fails++;
          $display("[TB] FAIL contention_grant cycle %0d: gnt=%b stall=%b required %0d %0d",
                   c, dbg_gnt, cpu_stall, (c == 4), (c == 4));
        end
      end
      if (c == 5) begin
        tests++;
        if (dut.wait_cnt !== 4'd0 || mem_en !== 1'b1 || mem_addr !== 8'd16) begin
          fails++;
          $display("[TB] FAIL contention_issue: wait_cnt=%0d en=%b addr=%0d required 0 1 16",
                   dut.wait_cnt, mem_en, mem_addr);
        end
      end
      if (c == 6) begin
        tests++;
        if (dbg_rvalid !== 1'b1 || dbg_rdata !== 64'd7 || cpu_rvalid !== 1'b0 || cpu_rdata !== 64'd0) begin
          fails++;
          $display("[TB] FAIL contention_return: drv=%b drd=%0d crv=%b crd=%0d required 1 7 0 0",
                   dbg_rvalid, dbg_rdata, cpu_rvalid, cpu_rdata);
        end
      end
    end
    next_cycle(); idle_inputs();
    next_cycle();
  endtask

  task automatic test_idle_cpu();
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      idle_inputs();
      if (c == 0) begin dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'd30; dbg_wdata = 64'h77; end
      if (c == 1) begin dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'd30; end
      @(negedge clk);
      if (c <= 1) begin
        tests++;
        if (dbg_gnt !== 1'b1 || cpu_stall !== 1'b0) begin
          fails++;
          $display("[TB] FAIL idle_grant cycle %0d: gnt=%b stall=%b required 1 0", c, dbg_gnt, cpu_stall);
        end
      end
      if (c == 1) begin
        tests++;
        if ({mem_en, mem_rw} !== 2'b11 || mem_addr !== 8'd30 || mem_wdata !== 64'h77) begin
          fails++;
          $display("[TB] FAIL idle_write_issue: en=%b rw=%b addr=%0d wdata=%0h required 1 1 30 77",
                   mem_en, mem_rw, mem_addr, mem_wdata);
        end
      end
      if (c == 2) begin
        tests++;
        if (dbg_rvalid !== 1'b0) begin
          fails++;
          $display("[TB] FAIL write_no_rvalid: got %b required 0", dbg_rvalid);
        end
      end
      if (c == 3) begin
        tests++;
        if (dbg_rvalid !== 1'b1 || dbg_rdata !== 64'h77) begin
          fails++;
          $display("[TB] FAIL idle_read_return: rvalid=%b rdata=%0h required 1 77", dbg_rvalid, dbg_rdata);
        end
      end
    end
  endtask

  task automatic test_halt();
    mem[5] = 64'h55;
    for (int k = 0; k < 10; k++) mem[11 + k] = 64'(100 + k);
    next_cycle(); idle_inputs();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'd5;
    next_cycle(); idle_inputs();
    halt = 1'b1;
    for (int c = 2; c < 14; c++) begin
      next_cycle();
      idle_inputs();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'd5; cpu_wdata = 64'hdead;
      if (c <= 11) begin dbg_req = 1'b1; dbg_addr = 8'(11 + c - 2); end
      @(negedge clk);
      if (c == 2) begin
        tests++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 64'h55) begin
          fails++;
          $display("[TB] FAIL halt_cpu_inflight: rvalid=%b rdata=%0h required 1 55", cpu_rvalid, cpu_rdata);
        end
      end else begin
        tests++;
        if (cpu_rvalid !== 1'b0) begin
          fails++;
          $display("[TB] FAIL halt_cpu_ignored cycle %0d: cpu_rvalid=%b required 0", c, cpu_rvalid);
        end
      end
      if (c <= 11) begin
        tests++;
        if (dbg_gnt !== 1'b1 || cpu_stall !== 1'b0) begin
          fails++;
          $display("[TB] FAIL halt_grant cycle %0d: gnt=%b stall=%b required 1 0", c, dbg_gnt, cpu_stall);
        end
      end
      if (c >= 3 && c <= 12) begin
        tests++;
        if (mem_en !== 1'b1 || mem_rw !== 1'b0 || mem_addr !== 8'(11 + c - 3)) begin
          fails++;
          $display("[TB] FAIL halt_issue cycle %0d: en=%b rw=%b addr=%0d required 1 0 %0d",
                   c, mem_en, mem_rw, mem_addr, 11 + c - 3);
        end
      end
      if (c >= 4) begin
        tests++;
        if (dbg_rvalid !== 1'b1 || dbg_rdata !== 64'(100 + c - 4)) begin
          fails++;
          $display("[TB] FAIL halt_return cycle %0d: rvalid=%b rdata=%0d required 1 %0d",
                   c, dbg_rvalid, dbg_rdata, 100 + c - 4);
        end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    next_cycle(); idle_inputs();
    dbg_req = 1'b1; dbg_addr = 8'd16;
    @(negedge clk);
    tests++;
    if (dbg_gnt !== 1'b1) begin
      fails++;
      $display("[TB] FAIL midrst_grant: gnt=%b required 1", dbg_gnt);
    end
    next_cycle(); idle_inputs();
    rst = 1'b0; dbg_req = 1'b1; cpu_req = 1'b1;
    @(negedge clk);
    tests++;
    if (dbg_gnt !== 1'b0 || cpu_stall !== 1'b0) begin
      fails++;
      $display("[TB] FAIL midrst_held: gnt=%b stall=%b required 0 0", dbg_gnt, cpu_stall);
    end
    next_cycle(); idle_inputs();
    rst = 1'b1; cpu_req = 1'b1; cpu_addr = 8'd42; dbg_req = 1'b1; dbg_addr = 8'd16;
    @(negedge clk);
    tests++;
    if (dbg_rvalid !== 1'b0 || mem_en !== 1'b0) begin
      fails++;
      $display("[TB] FAIL midrst_discard: rvalid=%b en=%b required 0 0", dbg_rvalid, mem_en);
    end
    tests++;
    if (cpu_stall !== 1'b0 || dbg_gnt !== 1'b0) begin
      fails++;
      $display("[TB] FAIL midrst_run_state: stall=%b gnt=%b required 0 0", cpu_stall, dbg_gnt);
    end
    next_cycle(); idle_inputs();
    @(negedge clk);
    tests++;
    if (mem_en !== 1'b1 || mem_addr !== 8'd42) begin
      fails++;
      $display("[TB] FAIL midrst_cpu_issue: en=%b addr=%0d required 1 42", mem_en, mem_addr);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem_rdata = '0;
    test_reset();
    test_cpu_only();
    test_contention();
    test_idle_cpu();
    test_halt();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbitrates the single data-memory port between the pipelined CPU's load/store stage and a debug/testbench access port (results readback, preload).
- Sits between top and Data_Mem and drives the memory's address and read/write strobe.
- CPU has priority. A starvation counter guarantees debug progress. After halt, the debug port owns the memory.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width.
- MAX_WAIT, 4, consecutive denied debug cycles before the debug port is forced a grant (1..15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- halt  in  1  CPU halt; sampled and latched
- cpu_req  in  1  CPU memory request
- cpu_we  in  1  1=store, 0=load
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU store data
- cpu_stall  out  1  request not accepted this cycle; CPU holds its request
- cpu_rvalid  out  1  CPU load data valid
- cpu_rdata  out  DATA_W  CPU load data
- dbg_req  in  1  debug request
- dbg_we  in  1  1=write, 0=read
- dbg_addr  in  ADDR_W  debug address
- dbg_wdata  in  DATA_W  debug write data
- dbg_gnt  out  1  debug request accepted this cycle
- dbg_rvalid  out  1  debug read data valid
- dbg_rdata  out  DATA_W  debug read data
- mem_rw  out  1  1=write, 0=read (valid when mem_en=1)
- mem_en  out  1  memory access strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after a read strobe

Behaviour:
- Reset (rst=0 at posedge):
  - state=RUN, wait_cnt=0, all pipeline tags cleared.
  - mem_en, mem_rw, dbg_rvalid, cpu_rvalid = 0; mem_addr, mem_wdata = 0.
  - In-flight reads are discarded; no rvalid is produced for them.
  - While rst=0, the grant outputs cpu_stall and dbg_gnt are 0.
- FSM, two states:
  - RUN: normal arbitration.
  - HALTED: entered at the posedge where halt=1 is sampled; sticky until reset.
- Grant decision (combinational, cycle N):
  - RUN, wait_cnt==MAX_WAIT and dbg_req=1: debug granted. cpu_stall=cpu_req.
  - RUN, otherwise: CPU granted if cpu_req=1, so cpu_stall=0. dbg_gnt=dbg_req & ~cpu_req.
  - HALTED: cpu_req ignored, cpu_stall=0. dbg_gnt=dbg_req.
  - Exactly one requester is granted per cycle. dbg_gnt and an accepted CPU request are never both true.
- Starvation counter, updated at posedge:
  - Increments when dbg_req & ~dbg_gnt, saturating at MAX_WAIT.
  - Clears to 0 when dbg_gnt=1 or dbg_req=0.
- Issue stage:
  - The granted request is registered onto mem_en/mem_rw/mem_addr/mem_wdata in cycle N+1.
  - With no grant, mem_en=0 in N+1. mem_addr and mem_wdata hold their previous values.
- Read return:
  - A read issued in N+1 returns mem_rdata in N+2.
  - The owner tag is delayed one cycle. The owner's rvalid is 1 in N+2 only, and its rdata=mem_rdata.
  - The other port's rdata is 0.
  - Writes produce no rvalid.
  - Read latency from grant is 2 cycles. Throughput is one access per cycle, back-to-back, with no bubble between owners.
- Halt mid-operation: accesses already granted (including a CPU read in flight) complete and return normally.
- Same-address write then read in consecutive grants: the read returns the new data (memory ordering is preserved by the in-order issue).

Test Plan:
- Reset: hold rst=0 for 10 cycles with cpu_req=dbg_req=1 -> mem_en=0, cpu_rvalid=dbg_rvalid=0, cpu_stall=0, dbg_gnt=0 throughout.
- CPU-only:
  - CPU store addr=8, data=55, then load addr=8 on the next cycle.
  - -> mem_en/mem_rw=1 one cycle after the store grant.
  - -> cpu_rvalid=1 with cpu_rdata=55 two cycles after the load grant.
  - -> cpu_stall=0 throughout.
- Contention:
  - cpu_req held high continuously, dbg read addr=16 (preloaded 7), MAX_WAIT=4.
  - -> dbg_gnt=0 for 4 cycles, then dbg_gnt=1 and cpu_stall=1 for exactly that cycle.
  - -> dbg_rvalid=1, dbg_rdata=7 two cycles later; wait_cnt returns to 0.
- Idle CPU: dbg_req with cpu_req=0 -> dbg_gnt=1 in the same cycle, 0 wait.
- Halt:
  - CPU load in flight, halt pulse 1 cycle, then debug reads addr 11..20 back-to-back.
  - -> CPU load completes with cpu_rvalid.
  - -> after halt, cpu_req is ignored and 10 consecutive dbg_gnt occur with one dbg_rvalid per cycle.
- Reset mid-read: rst=0 in the cycle after a debug read grant -> no dbg_rvalid; state returns to RUN, so a subsequent cpu_req is granted.
